mult_arbiter: RTL and testbench



---
 rtl/nn_pkg.sv | 33 +++
 rtl/mult_seq_signed.sv | 85 ++++++++
 rtl/mult_arbiter.sv | 148 ++++++++++++++
 tb/tb_mult_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and helpers for the layer-level multiplier arbiter.
package nn_pkg;

    localparam int unsigned MaxReq = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL     = 2'd1,
        ST_RELEASE = 2'd2
    } mult_arb_st_e;

    // First set bit of req at or after ptr, wrapping modulo n; returns ptr when none is set.
    function automatic int unsigned rr_pick(input logic [MaxReq-1:0] req,
                                            input int unsigned ptr,
                                            input int unsigned n);
        int unsigned pick;
        int unsigned idx;
        int unsigned k;
        logic [4:0] sel;
        pick = ptr;
        for (int unsigned j = 0; j < MaxReq; j++) begin
            k = MaxReq - 1 - j;
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                sel = idx[4:0];
                if (req[sel]) pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mult_seq_signed.sv
// Iterative radix-2 signed shift-add multiplier; one partial product per cycle,
// the sign bit of b contributes with negative weight.
module mult_seq_signed #(
    parameter int unsigned DataWidth = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     start_i,
    input  logic                     clear_i,
    input  logic [DataWidth-1:0]     a_i,
    input  logic [DataWidth-1:0]     b_i,
    output logic                     busy_o,
    output logic                     last_o,
    output logic                     done_o,
    output logic [2*DataWidth-1:0]   product_o
);

    localparam int unsigned CntW = $clog2(DataWidth + 1);

    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [2*DataWidth-1:0] mcand_q, mcand_d;
    logic [DataWidth-1:0]   mplier_q, mplier_d;
    logic [2*DataWidth-1:0] acc_q, acc_d;
    logic [2*DataWidth-1:0] prod_q, prod_d;
    logic [2*DataWidth-1:0] addend;

    assign last_o = busy_q && (cnt_q == CntW'(DataWidth - 1));

    always_comb begin
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        prod_d   = prod_q;
        addend   = mplier_q[0] ? mcand_q : '0;
        if (clear_i) begin
            busy_d = 1'b0;
        end else if (start_i) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = {{DataWidth{a_i[DataWidth-1]}}, a_i};
            mplier_d = b_i;
            acc_d    = '0;
        end else if (busy_q) begin
            acc_d    = last_o ? (acc_q - addend) : (acc_q + addend);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (last_o) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                prod_d = acc_d;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            prod_q   <= '0;
        end else begin
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            prod_q   <= prod_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = prod_q;

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one sequential signed multiplier among a layer's neurons.
// Define MULT_ARB_STATS_EN to add the ops_o / stall_o activity counters.
module mult_arbiter
    import nn_pkg::*;
#(
    parameter int unsigned NumReq    = 5,
    parameter int unsigned DataWidth = 8
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    input  logic [NumReq-1:0]             req_i,
    input  logic [NumReq-1:0]             start_i,
    input  logic [NumReq*DataWidth-1:0]   a_i,
    input  logic [NumReq*DataWidth-1:0]   b_i,
`ifdef MULT_ARB_STATS_EN
    output logic [31:0]                   ops_o,
    output logic [31:0]                   stall_o,
`endif
    output logic [NumReq-1:0]             grant_o,
    output logic [NumReq-1:0]             done_o,
    output logic [NumReq-1:0]             busy_o,
    output logic [2*DataWidth-1:0]        result_o
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    mult_arb_st_e         state_q, state_d;
    logic [IdxW-1:0]      owner_q, owner_d;
    logic [IdxW-1:0]      ptr_q, ptr_d;
    logic [NumReq-1:0]    grant_q, grant_d;
    logic [NumReq-1:0]    eligible;
    logic [NumReq-1:0]    owner_oh;
    logic [IdxW-1:0]      win;
    logic [IdxW-1:0]      owner_next;
    int unsigned          win_int;
    logic                 mult_start, mult_clear, mult_busy, mult_last, mult_done;
    logic [DataWidth-1:0] op_a, op_b;

    assign eligible   = req_i & start_i;
    assign owner_oh   = NumReq'(1) << owner_q;
    assign win_int    = rr_pick(MaxReq'(eligible), 32'(ptr_q), NumReq);
    assign win        = win_int[IdxW-1:0];
    assign owner_next = (32'(owner_q) == NumReq - 1) ? '0 : owner_q + 1'b1;
    assign op_a       = a_i[win_int*DataWidth +: DataWidth];
    assign op_b       = b_i[win_int*DataWidth +: DataWidth];

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        mult_start = 1'b0;
        mult_clear = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    grant_d    = NumReq'(1) << win;
                    owner_d    = win;
                    mult_start = 1'b1;
                    state_d    = ST_MUL;
                end
            end
            ST_MUL: begin
                // Abort wins over completion so a dropped request never sees done_o.
                if (!req_i[owner_q]) begin
                    grant_d    = '0;
                    ptr_d      = owner_next;
                    mult_clear = 1'b1;
                    state_d    = ST_IDLE;
                end else if (mult_last) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!req_i[owner_q]) begin
                    grant_d = '0;
                    ptr_d   = owner_next;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    mult_seq_signed #(
        .DataWidth (DataWidth)
    ) u_mult (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .start_i   (mult_start),
        .clear_i   (mult_clear),
        .a_i       (op_a),
        .b_i       (op_b),
        .busy_o    (mult_busy),
        .last_o    (mult_last),
        .done_o    (mult_done),
        .product_o (result_o)
    );

    assign grant_o = grant_q;
    assign busy_o  = {NumReq{state_q == ST_MUL}};
    assign done_o  = mult_done ? owner_oh : '0;

`ifdef MULT_ARB_STATS_EN
    logic [31:0] ops_q, ops_d, stall_q, stall_d;

    always_comb begin
        ops_d   = ops_q;
        stall_d = stall_q;
        if (mult_done) ops_d = ops_q + 32'd1;
        if ((state_q != ST_IDLE) && |(eligible & ~owner_oh)) stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ops_q   <= '0;
            stall_q <= '0;
        end else begin
            ops_q   <= ops_d;
            stall_q <= stall_d;
        end
    end

    assign ops_o   = ops_q;
    assign stall_o = stall_q;
`endif

    logic unused_busy;
    assign unused_busy = mult_busy;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed self-checking bench for mult_arbiter (NumReq=5, DataWidth=8).
module tb_mult_arbiter;

    localparam int unsigned NumReq    = 5;
    localparam int unsigned DataWidth = 8;

    logic                        clk_i;
    logic                        reset_ni;
    logic [NumReq-1:0]           req_i;
    logic [NumReq-1:0]           start_i;
    logic [NumReq*DataWidth-1:0] a_i;
    logic [NumReq*DataWidth-1:0] b_i;
    logic [NumReq-1:0]           grant_o;
    logic [NumReq-1:0]           done_o;
    logic [NumReq-1:0]           busy_o;
    logic [2*DataWidth-1:0]      result_o;
`ifdef MULT_ARB_STATS_EN
    logic [31:0]                 ops_o;
    logic [31:0]                 stall_o;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    mult_arbiter #(
        .NumReq    (NumReq),
        .DataWidth (DataWidth)
    ) dut (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .req_i    (req_i),
        .start_i  (start_i),
        .a_i      (a_i),
        .b_i      (b_i),
`ifdef MULT_ARB_STATS_EN
        .ops_o    (ops_o),
        .stall_o  (stall_o),
`endif
        .grant_o  (grant_o),
        .done_o   (done_o),
        .busy_o   (busy_o),
        .result_o (result_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Lone requester runs one full operation and then releases.
    task automatic do_op(input int idx, input logic [7:0] av, input logic [7:0] bv,
                         input logic [15:0] exp);
        logic early;
        logic [4:0] oh;
        oh = 5'd1 << idx;
        a_i[idx*8 +: 8] = av;
        b_i[idx*8 +: 8] = bv;
        req_i[idx]   = 1'b1;
        start_i[idx] = 1'b1;
        tick();
        check_eq("op_grant", 32'(grant_o), 32'(oh));
        check_eq("op_busy", 32'(busy_o), 32'h1f);
        start_i[idx] = 1'b0;
        early = 1'b0;
        for (int k = 1; k < 8; k++) begin
            tick();
            if (done_o != 5'd0) early = 1'b1;
        end
        check_eq("op_no_early_done", 32'(early), 32'd0);
        tick();
        check_eq("op_done", 32'(done_o), 32'(oh));
        check_eq("op_result", 32'(result_o), 32'(exp));
        check_eq("op_busy_release", 32'(busy_o), 32'd0);
        tick();
        check_eq("op_done_one_cycle", 32'(done_o), 32'd0);
        check_eq("op_grant_held", 32'(grant_o), 32'(oh));
        req_i[idx] = 1'b0;
        tick();
        check_eq("op_grant_cleared", 32'(grant_o), 32'd0);
    endtask

    int          order[6]    = '{0, 1, 2, 3, 4, 0};
    logic [15:0] prod_tab[5] = '{16'd3, 16'd6, 16'd9, 16'd12, 16'd15};

    initial begin
        int   cyc;
        int   w;
        logic multi;
        logic seen;

        req_i    = '0;
        start_i  = '0;
        a_i      = '0;
        b_i      = '0;
        reset_ni = 1'b1;
        #2 reset_ni = 1'b0;
        #10;
        check_eq("rst_grant", 32'(grant_o), 32'd0);
        check_eq("rst_done", 32'(done_o), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_result", 32'(result_o), 32'd0);
`ifdef MULT_ARB_STATS_EN
        check_eq("rst_ops", ops_o, 32'd0);
        check_eq("rst_stall", stall_o, 32'd0);
`endif
        @(negedge clk_i) reset_ni = 1'b1;
        tick();

        do_op(2, 8'hFD, 8'h07, 16'hFFEB);
        do_op(0, 8'h80, 8'h80, 16'h4000);
        do_op(4, 8'h7F, 8'h80, 16'hC080);
        do_op(1, 8'h00, 8'h5A, 16'h0000);
        do_op(3, 8'h81, 8'h7F, 16'hC0FF);
`ifdef MULT_ARB_STATS_EN
        check_eq("ops_after_singles", ops_o, 32'd5);
`endif

        // Contention: pulse the reset so the round-robin pointer restarts at 0.
        reset_ni = 1'b0;
        tick();
        reset_ni = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            a_i[i*8 +: 8] = 8'(i + 1);
            b_i[i*8 +: 8] = 8'd3;
        end
        req_i   = '1;
        start_i = '1;
        multi   = 1'b0;
        for (int op = 0; op < 6; op++) begin
            w   = order[op];
            cyc = 0;
            while (grant_o == 5'd0 && cyc < 30) begin
                tick();
                cyc++;
                if ($countones(grant_o) > 1) multi = 1'b1;
            end
            check_eq("rr_grant", 32'(grant_o), 32'd1 << w);
            cyc = 0;
            while (done_o == 5'd0 && cyc < 30) begin
                tick();
                cyc++;
                if ($countones(grant_o) > 1) multi = 1'b1;
            end
            check_eq("rr_done_owner", 32'(done_o), 32'd1 << w);
            check_eq("rr_result", 32'(result_o), 32'(prod_tab[w]));
            req_i[w] = 1'b0;
            tick();
            req_i[w] = 1'b1;
        end
        check_eq("rr_onehot0", 32'(multi), 32'd0);
        req_i   = '0;
        start_i = '0;
        tick();

        // Start gating: 1 requests without start, 3 fully eligible.
        req_i   = 5'b01010;
        start_i = 5'b01000;
        tick();
        check_eq("gate_grant3", 32'(grant_o), 32'h08);
        start_i[1] = 1'b1;
        cyc = 0;
        while (done_o == 5'd0 && cyc < 30) begin
            tick();
            cyc++;
        end
        check_eq("gate_done3", 32'(done_o), 32'h08);
        check_eq("gate_result3", 32'(result_o), 32'd12);
        req_i[3] = 1'b0;
        tick();
        check_eq("gate_release", 32'(grant_o), 32'd0);
        tick();
        check_eq("gate_grant1", 32'(grant_o), 32'h02);
        req_i[1] = 1'b0;
        tick();
        check_eq("gate_abort_clear", 32'(grant_o), 32'd0);
        check_eq("gate_abort_result", 32'(result_o), 32'd12);
        start_i = '0;

        // Abort: owner 0 drops req during the third multiply cycle.
        req_i[0]   = 1'b1;
        start_i[0] = 1'b1;
        tick();
        check_eq("abort_grant0", 32'(grant_o), 32'h01);
        req_i[1]   = 1'b1;
        start_i[1] = 1'b1;
        seen = 1'b0;
        tick();
        if (done_o != 5'd0) seen = 1'b1;
        tick();
        if (done_o != 5'd0) seen = 1'b1;
        req_i[0] = 1'b0;
        tick();
        check_eq("abort_grant_drop", 32'(grant_o), 32'd0);
        check_eq("abort_busy", 32'(busy_o), 32'd0);
        tick();
        check_eq("abort_next_grant", 32'(grant_o), 32'h02);
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done_o != 5'd0) seen = 1'b1;
        end
        check_eq("abort_no_done", 32'(seen), 32'd0);
        check_eq("abort_result_kept", 32'(result_o), 32'd12);
        cyc = 0;
        while (done_o == 5'd0 && cyc < 30) begin
            tick();
            cyc++;
        end
        check_eq("abort_done1", 32'(done_o), 32'h02);
        check_eq("abort_result1", 32'(result_o), 32'd6);
        req_i   = '0;
        start_i = '0;
        tick();

        // Async reset in the middle of a multiply, away from the clock edge.
        a_i[4*8 +: 8] = 8'hFD;
        b_i[4*8 +: 8] = 8'h07;
        req_i[4]   = 1'b1;
        start_i[4] = 1'b1;
        tick();
        check_eq("arst_pre_grant", 32'(grant_o), 32'h10);
        tick();
        tick();
        #3 reset_ni = 1'b0;
        #1;
        check_eq("arst_grant", 32'(grant_o), 32'd0);
        check_eq("arst_busy", 32'(busy_o), 32'd0);
        check_eq("arst_done", 32'(done_o), 32'd0);
        check_eq("arst_result", 32'(result_o), 32'd0);
`ifdef MULT_ARB_STATS_EN
        check_eq("arst_ops", ops_o, 32'd0);
        check_eq("arst_stall", stall_o, 32'd0);
`endif
        req_i   = '0;
        start_i = '0;
        @(negedge clk_i) reset_ni = 1'b1;
        tick();
        check_eq("arst_after_release", 32'(grant_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
